// File: rtl/sc_par_decode_if.sv
// Frame-level handshake bundle for the parallel SC decoder: per-pixel input bits,
// start request, decoded pixel array and the valid/ready/busy status.
interface sc_par_decode_if #(
  parameter int m = 32,
  parameter int n = 32,
  parameter int N = 8
);
  logic         start;
  logic         in_bits [0:m*n-1];
  logic [N-1:0] out_pix [0:m*n-1];
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output start, in_bits, out_ready,
    input  out_pix, out_valid, busy
  );

  modport slave (
    input  start, in_bits, out_ready,
    output out_pix, out_valid, busy
  );
endinterface

// File: rtl/sc_par_decode.sv
// Parallel stochastic-to-binary decoder: counts ones per pixel over 2^N cycles and
// presents the whole m x n frame as saturated N-bit values behind valid/ready.
module sc_par_decode #(
  parameter int m           = 32,
  parameter int n           = 32,
  parameter int N           = 8,
  parameter bit BORDER_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  sc_par_decode_if.slave bus
);

  localparam int           P    = m * n;
  localparam logic [N-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t       state;
  logic [N-1:0] sample_cnt;
  logic         valid_q;
  logic         busy_q;

  logic clear;
  logic accum_en;
  logic last_edge;

  // Counters restart either from IDLE or on a HOLD handshake that also carries start.
  assign clear     = bus.start && ((state == IDLE) || (state == HOLD && valid_q && bus.out_ready));
  assign accum_en  = (state == ACCUM);
  assign last_edge = accum_en && (sample_cnt == LAST);

  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          sample_cnt <= sample_cnt + 1'b1;
          if (sample_cnt == LAST) begin
            state   <= HOLD;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              state      <= ACCUM;
              sample_cnt <= '0;
              busy_q     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_pix
    localparam int ROW    = k / n;
    localparam int COL    = k % n;
    localparam bit BORDER = (ROW == 0) || (ROW == m - 1) || (COL == 0) || (COL == n - 1);

    if (BORDER_ZERO && BORDER) begin : g_zero
      assign bus.out_pix[k] = '0;
    end else begin : g_cnt
      logic [N:0]   count;
      logic [N:0]   total;
      logic [N-1:0] pix_q;

      // Includes the current bit so the final edge sees the full 2^N-sample count.
      assign total = count + {{N{1'b0}}, bus.in_bits[k]};

      // NOTE: the per-pixel registers are reset individually because a frame abort must blank the outputs at once.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
          pix_q <= '0;
        end else begin
          if (clear) begin
            count <= '0;
          end else if (accum_en) begin
            count <= total;
          end
          if (last_edge) begin
            pix_q <= total[N] ? '1 : total[N-1:0];
          end
        end
      end

      assign bus.out_pix[k] = pix_q;
    end
  end

endmodule

// File: tb/tb_sc_par_decode.sv
// Scoreboard bench for sc_par_decode (4x4 frame, 16-sample streams), checking a
// border-zeroing instance and a full-decode instance side by side.
module tb_sc_par_decode;

  localparam int TM = 4;
  localparam int TN = 4;
  localparam int TW = 4;
  localparam int P  = TM * TN;

  logic clk;
  logic rst_n;

  sc_par_decode_if #(.m(TM), .n(TN), .N(TW)) bus1 ();
  sc_par_decode_if #(.m(TM), .n(TN), .N(TW)) bus0 ();

  sc_par_decode #(.m(TM), .n(TN), .N(TW), .BORDER_ZERO(1'b1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  sc_par_decode #(.m(TM), .n(TN), .N(TW), .BORDER_ZERO(1'b0)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] q1 [$];
  logic [63:0] q0 [$];
  logic [15:0] pat [0:P-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel 0 lands in the most significant nibble so expected frames read row by row.
  task automatic sample(output logic [63:0] p1, output logic [63:0] p0);
    p1 = '0;
    p0 = '0;
    for (int k = 0; k < P; k++) begin
      p1[63-4*k -: 4] = bus1.out_pix[k];
      p0[63-4*k -: 4] = bus0.out_pix[k];
    end
  endtask

  task automatic check_state(input string name, input logic ev, input logic eb);
    check(name, {60'd0, bus1.out_valid, bus1.busy, bus0.out_valid, bus0.busy},
          {60'd0, ev, eb, ev, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_start(input logic v);
    bus1.start = v;
    bus0.start = v;
  endtask

  task automatic set_ready(input logic v);
    bus1.out_ready = v;
    bus0.out_ready = v;
  endtask

  task automatic set_bits(input int s);
    for (int k = 0; k < P; k++) begin
      bus1.in_bits[k] = pat[k][15-s];
      bus0.in_bits[k] = pat[k][15-s];
    end
  endtask

  task automatic rand_bits();
    for (int k = 0; k < P; k++) begin
      bus1.in_bits[k] = 1'($urandom_range(1));
      bus0.in_bits[k] = bus1.in_bits[k];
    end
  endtask

  task automatic set_pat(input logic [15:0] border, input logic [15:0] p5,
                         input logic [15:0] p6, input logic [15:0] p9, input logic [15:0] p10);
    for (int k = 0; k < P; k++) begin
      pat[k] = border;
    end
    pat[5]  = p5;
    pat[6]  = p6;
    pat[9]  = p9;
    pat[10] = p10;
  endtask

  // Issue one frame: start edge (optionally as a HOLD handshake), then 16 sample edges.
  task automatic run_frame(input logic [63:0] e1, input logic [63:0] e0,
                           input logic handshake, input int pulse_at);
    q1.push_back(e1);
    q0.push_back(e0);
    set_start(1'b1);
    set_ready(handshake);
    tick();
    set_start(1'b0);
    set_ready(1'b0);
    check_state("after start edge", 1'b0, 1'b1);
    for (int s = 0; s < 16; s++) begin
      set_bits(s);
      set_start(s == pulse_at);
      tick();
      check_state(s == 15 ? "after final sample" : "during accum", s == 15, s != 15);
    end
    set_start(1'b0);
  endtask

  task automatic drain();
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    check_state("after handshake", 1'b0, 1'b0);
  endtask

  // Monitor: compares the presented frame against the queue head every cycle it is valid.
  always @(negedge clk) begin
    logic [63:0] a1, a0;
    sample(a1, a0);
    if (bus1.out_valid) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected valid", 64'd1, 64'd0);
      end else begin
        check("dut1 frame", a1, q1[0]);
        if (bus1.out_ready) void'(q1.pop_front());
      end
    end
    if (bus0.out_valid) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected valid", 64'd1, 64'd0);
      end else begin
        check("dut0 frame", a0, q0[0]);
        if (bus0.out_ready) void'(q0.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p1, p0;

    rst_n = 1'b0;
    set_start(1'b0);
    set_ready(1'b0);
    for (int k = 0; k < P; k++) pat[k] = '0;
    rand_bits();

    // Reset held with random inputs, then released with start low.
    for (int c = 0; c < 3; c++) begin
      set_start(1'($urandom_range(1)));
      set_ready(1'($urandom_range(1)));
      rand_bits();
      tick();
      sample(p1, p0);
      check_state("in reset", 1'b0, 1'b0);
      check("in reset pix", {p1, 1'b0} | {p0, 1'b0}, 65'd0);
    end
    set_start(1'b0);
    set_ready(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_bits();
      tick();
      sample(p1, p0);
      check_state("idle after reset", 1'b0, 1'b0);
      check("idle pix", p1 | p0, 64'd0);
    end

    // Full scale: every stream all ones saturates at 15.
    set_pat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_frame(64'h0000_0FF0_0FF0_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
    drain();

    // Mixed interior patterns: 1010.., 1000.., all zero, four ones then zeros.
    set_pat(16'h0000, 16'hAAAA, 16'h8888, 16'h0000, 16'hF000);
    run_frame(64'h0000_0840_0040_0000, 64'h0000_0840_0040_0000, 1'b0, -1);
    drain();

    // Border inputs high, interior low.
    set_pat(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_frame(64'h0000_0000_0000_0000, 64'hFFFF_F00F_F00F_FFFF, 1'b0, -1);
    drain();

    // Backpressure: HOLD for 5 cycles with a start pulse that must be ignored.
    set_pat(16'h0300, 16'h00FF, 16'h0001, 16'hFFFE, 16'h0F0F);
    run_frame(64'h0000_0810_0F80_0000, 64'h2222_2812_2F82_2222, 1'b0, -1);
    for (int c = 0; c < 5; c++) begin
      set_start(c == 2);
      tick();
      check_state("hold under backpressure", 1'b1, 1'b0);
    end
    set_start(1'b0);

    // Handshake and restart on the same edge, with a stray start mid-accumulation.
    set_pat(16'h0000, 16'hAAAA, 16'h8888, 16'h0000, 16'hF000);
    run_frame(64'h0000_0840_0040_0000, 64'h0000_0840_0040_0000, 1'b1, 5);
    drain();

    // Asynchronous reset after 7 samples must blank the outputs immediately.
    set_pat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int s = 0; s < 7; s++) begin
      set_bits(s);
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    sample(p1, p0);
    check_state("async reset mid frame", 1'b0, 1'b0);
    check("async reset pix", p1 | p0, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_state("idle after abort", 1'b0, 1'b0);

    // Fresh all-ones frame after the abort carries no residue.
    run_frame(64'h0000_0FF0_0FF0_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1);
    drain();

    for (int c = 0; c < 10 && (q1.size() != 0 || q0.size() != 0); c++) tick();
    check("dut1 frames outstanding", 64'(q1.size()), 64'd0);
    check("dut0 frames outstanding", 64'(q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_par_decode.md
# sc_par_decode

Parallel stochastic-to-binary decoder for an m by n frame of SC bitstreams. It sits at the output end of the SC image pipeline, after the parallel 3x3 median noise filter. It counts the ones in each pixel's bitstream over a fixed window of 2^N clock cycles, then presents every pixel as an N-bit binary value through a valid/ready handshake. Upstream filters leave border pixels undriven, so border outputs can be forced to zero.

## Interface
Parameters:
- m, 32, frame rows
- n, 32, frame columns
- N, 8, log2 of bitstream length L = 2^N; also the output pixel width
- BORDER_ZERO, 1, when 1, pixels in row 0, row m-1, column 0 and column n-1 always output 0 and their inputs are ignored

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to decode a new frame; honoured only in IDLE, or in HOLD on the same cycle as the handshake
- in_bits  input  1 x m*n (unpacked [0:m*n-1])  per-pixel SC bit for this cycle, row-major, index i*n+j
- out_pix  output  N x m*n (unpacked [0:m*n-1])  decoded pixel values, row-major
- out_valid  output  1  out_pix holds a complete frame
- out_ready  input  1  consumer accepts the frame
- busy  output  1  high while in ACCUM

## Operation
FSM states and transitions:
- IDLE: start=1 moves to ACCUM. On that edge all pixel counters clear to 0 and the sample counter clears to 0.
- ACCUM: every edge adds in_bits[k] to counter k and increments the sample counter. start is ignored.
  - On the edge where the sample counter equals 2^N-1, the final bit is included and each out_pix[k] loads min(count_k + bit_k, 2^N-1).
  - On that same edge out_valid goes to 1 and the state moves to HOLD.
- HOLD: out_pix and out_valid are held stable.
  - out_valid & out_ready with start=0 moves to IDLE, and out_valid clears.
  - out_valid & out_ready with start=1 moves directly to ACCUM, clears the counters, and clears out_valid.
  - start without out_ready is ignored.

Arithmetic:
- Each pixel counter is N+1 bits, because the maximum count is 2^N.
- The output saturates at 2^N-1, so an all-ones stream reads 2^N-1.
- The sample counter is N bits and its terminal value is 2^N-1. It never wraps inside a frame.

Border handling:
- With BORDER_ZERO=1, border out_pix are constant 0 and need no counters.
- With BORDER_ZERO=0, every pixel is decoded identically.

Reset (reset=0, asynchronous):
- state returns to IDLE; out_valid=0, busy=0, all out_pix=0, all counters=0.
- Reset mid-ACCUM or mid-HOLD aborts the frame; no partial result is ever presented.
- Outputs are zero while reset is held and after it is released, until a frame completes.

## Timing
- start is sampled at edge E0. Bits are sampled at edges E1 through E2^N.
- out_valid is high after edge E2^N; decode latency is 2^N cycles from the start edge.
- busy is high from after E0 until after E2^N.
- Minimum frame-to-frame period is 2^N+1 cycles: start is taken on the handshake edge and there is no idle gap.
- out_pix changes only on the final ACCUM edge or on reset; it is constant throughout HOLD.
- Simultaneous start and out_ready in HOLD: the handshake completes and the new frame starts on the same edge.

## Test plan
Use m=n=4, N=4 (L=16), BORDER_ZERO=1 unless stated.
- Reset: hold reset=0 for 3 cycles with random inputs -> out_valid=0, busy=0, all out_pix=0. Release with start=0 for 10 cycles -> outputs unchanged.
- Full scale: all in_bits=1, pulse start -> busy for 16 cycles, out_valid after the 16th sample edge. The four interior pixels (indices 5, 6, 9, 10) read 15 (saturated); border pixels read 0.
- Mixed patterns: interior pixels driven 1010..., 1000..., all-0 and 4-ones-then-0 -> out_pix = 8, 4, 0, 4 respectively.
- Border: BORDER_ZERO=0, all in_bits=1 -> all 16 pixels read 15. BORDER_ZERO=1 with border inputs 1 and interior 0 -> all 0.
- Backpressure and restart:
  - Hold out_ready=0 for 5 cycles and pulse start during HOLD -> out_pix stable, start ignored.
  - Then out_ready=1 together with start=1 -> out_valid drops, busy rises on the same edge, and the second frame's result is correct.
  - A start pulse during ACCUM has no effect.
- Async reset mid-frame: assert reset between edges after 7 samples -> outputs are 0 immediately, without waiting for an edge. A fresh start with all-ones -> 15, with no residue from the aborted frame.
